// File: rtl/wam_hit_ctrl.sv
// Whac-A-Mole switch debouncer and hit qualifier: per-channel tap filter, mole lockout, saturating score.
// Define WAM_MISS_EN to generate the per-channel miss pulses; otherwise miss is tied to 0.
module wam_hit_ctrl #(
   parameter int N_CH      = 8,
   parameter int DB_CNT    = 5,
   parameter int EDGE_MODE = 0,
   parameter int CNT_W     = 8
) (
   input  logic             clk_19,
   input  logic             rst,
   input  logic [N_CH-1:0]  sw,
   input  logic [N_CH-1:0]  holes,
   output logic [N_CH-1:0]  tap,
   output logic [N_CH-1:0]  hit,
   output logic [N_CH-1:0]  miss,
   output logic [CNT_W-1:0] score
);

   localparam int CW    = $clog2(DB_CNT + 1);
   localparam int PC_W  = $clog2(N_CH + 1);
   localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

   localparam logic [CW-1:0]    DB_LAST   = CW'(DB_CNT);
   localparam logic [CNT_W-1:0] SCORE_MAX = {CNT_W{1'b1}};

   typedef enum logic {
      IDLE = 1'b0,
      FILT = 1'b1
   } state_t;

   state_t          state_q [N_CH];
   state_t          state_d [N_CH];
   logic [CW-1:0]   cnt_q   [N_CH];
   logic [CW-1:0]   cnt_d   [N_CH];

   logic [N_CH-1:0] sw_q;
   logic [N_CH-1:0] holes_q;
   logic [N_CH-1:0] edg;
   logic [N_CH-1:0] qual;
   logic [N_CH-1:0] tap_d;
   logic [N_CH-1:0] hit_d;
   logic [N_CH-1:0] lock;
   logic [N_CH-1:0] lock_d;

   logic [PC_W-1:0]  hit_cnt;
   logic [SUM_W-1:0] score_sum;
   logic [CNT_W-1:0] score_d;

   assign edg  = sw ^ sw_q;
   assign qual = (EDGE_MODE == 1) ? (edg & sw) : edg;

   // Debounce FSM next-state: any edge while filtering aborts, and that edge is not a restart.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         // NOTE: every always_comb output gets a default first so no path can infer a latch.
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         tap_d[i]   = 1'b0;
         case (state_q[i])
            IDLE: begin
               if (qual[i]) begin
                  state_d[i] = FILT;
                  cnt_d[i]   = CW'(1);
               end
            end
            FILT: begin
               if (edg[i]) begin
                  state_d[i] = IDLE;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == DB_LAST) begin
                  state_d[i] = IDLE;
                  cnt_d[i]   = '0;
                  tap_d[i]   = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + CW'(1);
               end
            end
         endcase
      end
   end

   // A mole leaving its hole clears the lock, which wins over a simultaneous set.
   assign hit_d  = tap & holes_q & ~lock;
   assign lock_d = holes_q & (lock | hit_d);

   always_comb begin
      hit_cnt = '0;
      for (int i = 0; i < N_CH; i++) begin
         hit_cnt = hit_cnt + PC_W'(hit[i]);
      end
      score_sum = SUM_W'(score) + SUM_W'(hit_cnt);
      score_d   = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[CNT_W-1:0];
   end

   // sw_q follows sw even in reset so levels held through reset never look like edges.
   always_ff @(posedge clk_19) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      sw_q <= sw;
      if (rst) begin
         holes_q <= '0;
         tap     <= '0;
         hit     <= '0;
         lock    <= '0;
         score   <= '0;
         // NOTE: the per-channel state arrays are small control registers, so they are reset explicitly.
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
         end
      end else begin
         holes_q <= holes;
         tap     <= tap_d;
         hit     <= hit_d;
         lock    <= lock_d;
         score   <= score_d;
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

`ifdef WAM_MISS_EN
   // Locked channels with a mole up are deliberately neither hit nor miss.
   always_ff @(posedge clk_19) begin
      if (rst) begin
         miss <= '0;
      end else begin
         miss <= tap & ~holes_q;
      end
   end
`else
   assign miss = '0;
`endif

endmodule
